// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-way arbiter for a single shared resource.
// Rotating or fixed priority selection. A grant is held until its owner drops
// its request or the hold limit expires. Grant, index, valid and timeout are
// all registered so they can drive the resource mux select directly.
module rr_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       rr_en,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    // MAX_HOLD must fit in CNT_W bits; a value of zero disables the limit.
    localparam bit               HOLD_EN    = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]       gnt_q, gnt_d;
    logic [2:0]       gnt_id_q, gnt_id_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q, timeout_d;

    logic [2:0]       search_start;
    logic [2:0]       cand;
    logic [2:0]       winner;
    logic             found;

    // Priority search: walk downward from the start index, wrapping mod 8.
    always_comb begin
        search_start = rr_en ? ptr_q : 3'd7;
        cand         = 3'd0;
        winner       = 3'd0;
        found        = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cand = search_start - 3'(i);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Next-state and output logic: arbitrate in IDLE, hold or release in GRANT.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;

        case (state_q)
            IDLE: begin
                gnt_d       = 8'd0;
                gnt_id_d    = 3'd0;
                gnt_valid_d = 1'b0;
                hold_cnt_d  = '0;
                if (found) begin
                    state_d     = GRANT;
                    gnt_d       = 8'b1 << winner;
                    gnt_id_d    = winner;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = CNT_ONE;
                end
            end

            GRANT: begin
                // The owner dropping its request wins over the hold limit,
                // so a release on the limit edge never flags a timeout.
                if (!req[gnt_id_q]) begin
                    state_d     = IDLE;
                    gnt_d       = 8'd0;
                    gnt_id_d    = 3'd0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                    ptr_d       = gnt_id_q - 3'd1;
                end else if (HOLD_EN && (hold_cnt_q == HOLD_LIMIT)) begin
                    state_d     = IDLE;
                    gnt_d       = 8'd0;
                    gnt_id_d    = 3'd0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                    ptr_d       = gnt_id_q - 3'd1;
                    timeout_d   = 1'b1;
                end else if (hold_cnt_q != CNT_MAX) begin
                    hold_cnt_d  = hold_cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d     = IDLE;
                gnt_d       = 8'd0;
                gnt_id_d    = 3'd0;
                gnt_valid_d = 1'b0;
                hold_cnt_d  = '0;
            end
        endcase
    end

    // State and output registers; reset clears the grant without a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 3'd7;
            hold_cnt_q  <= '0;
            gnt_q       <= 8'd0;
            gnt_id_q    <= 3'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

    // Output invariants that the downstream mux select relies on.
    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(gnt_q));
    a_valid_match : assert property (@(posedge clk) disable iff (!rst_n)
        gnt_valid_q == (|gnt_q));
    a_id_encode : assert property (@(posedge clk) disable iff (!rst_n)
        gnt_valid_q ? (gnt_q == (8'b1 << gnt_id_q)) : (gnt_id_q == 3'd0));
    a_timeout_idle : assert property (@(posedge clk) disable iff (!rst_n)
        !(timeout_q && gnt_valid_q));

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: directed, table-driven bench for rr_arbiter_8.
module tb_rr_arbiter_8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       rr_en;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    logic [7:0] req2;
    logic       rr_en2;
    logic [7:0] gnt2;
    logic [2:0] gnt_id2;
    logic       gnt_valid2;
    logic       timeout2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       do_rst;
        int         sec;
        logic [7:0] req;
        logic       rr_en;
        logic [7:0] exp_gnt;
        logic [2:0] exp_id;
        logic       exp_timeout;
    } vec_t;

    vec_t vecs[$];

    rr_arbiter_8 #(.MAX_HOLD(16), .CNT_W(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .rr_en     (rr_en),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    rr_arbiter_8 #(.MAX_HOLD(0), .CNT_W(8)) u_nolimit (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req2),
        .rr_en     (rr_en2),
        .gnt       (gnt2),
        .gnt_id    (gnt_id2),
        .gnt_valid (gnt_valid2),
        .timeout   (timeout2)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends on its own.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [7:0] oh(input int k);
        logic [7:0] v;
        v = 8'b1 << k;
        return v;
    endfunction

    function automatic string secName(input int s);
        case (s)
            0: return "basic";
            1: return "fairness";
            2: return "fixed";
            3: return "wrap";
            4: return "timeout";
            5: return "limit_edge";
            default: return "misc";
        endcase
    endfunction

    function automatic void addVec(input logic do_rst, input int sec,
                                   input logic [7:0] r, input logic en,
                                   input logic [7:0] eg, input int eid,
                                   input logic eto);
        vec_t v;
        v.do_rst      = do_rst;
        v.sec         = sec;
        v.req         = r;
        v.rr_en       = en;
        v.exp_gnt     = eg;
        v.exp_id      = 3'(eid);
        v.exp_timeout = eto;
        vecs.push_back(v);
    endfunction

    // Pulse reset away from the clock edge, leaving inputs idle.
    task automatic doReset();
        req    = 8'd0;
        req2   = 8'd0;
        rst_n  = 1'b0;
        #2;
        rst_n  = 1'b1;
        #1;
    endtask

    // Drive inputs, take one rising edge, and settle just after it.
    task automatic applyStimulus(input logic [7:0] r, input logic en);
        req   = r;
        rr_en = en;
        @(posedge clk);
        #1;
    endtask

    // Compare all main-DUT outputs against the expected record.
    task automatic checkOutput(input string tag, input int idx,
                               input logic [7:0] eg, input logic [2:0] eid,
                               input logic eto);
        logic ev;
        ev = (eg != 8'd0);
        checks++;
        if (gnt !== eg || gnt_id !== eid || gnt_valid !== ev || timeout !== eto) begin
            errors++;
            $display("[TB] FAIL %s #%0d: got gnt=%b id=%0d valid=%b timeout=%b, expected gnt=%b id=%0d valid=%b timeout=%b",
                     tag, idx, gnt, gnt_id, gnt_valid, timeout, eg, eid, ev, eto);
        end
    endtask

    task automatic checkValue(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Build the vector table: inputs for each edge and the outputs expected after it.
    task automatic buildTable();
        // Basic grant, no preemption, release and next grant
        addVec(1, 0, 8'h24, 1, 8'h20, 5, 0);
        addVec(0, 0, 8'hE4, 1, 8'h20, 5, 0);
        addVec(0, 0, 8'h04, 1, 8'h00, 0, 0);
        addVec(0, 0, 8'h04, 1, 8'h04, 2, 0);
        addVec(0, 0, 8'h00, 1, 8'h00, 0, 0);

        // Round robin with all requesting; each owner holds 3 cycles then drops once
        for (int k = 7; k >= 0; k--) begin
            for (int j = 0; j < 3; j++)
                addVec((k == 7 && j == 0), 1, 8'hFF, 1, oh(k), k, 0);
            addVec(0, 1, 8'hFF & ~oh(k), 1, 8'h00, 0, 0);
        end
        addVec(0, 1, 8'hFF, 1, 8'h80, 7, 0);

        // Fixed priority: 7 keeps winning until it stops requesting
        addVec(1, 2, 8'hFF, 0, 8'h80, 7, 0);
        for (int r = 0; r < 3; r++) begin
            addVec(0, 2, 8'h7F, 0, 8'h00, 0, 0);
            addVec(0, 2, 8'hFF, 0, 8'h80, 7, 0);
        end
        addVec(0, 2, 8'h7F, 0, 8'h00, 0, 0);
        addVec(0, 2, 8'h7F, 0, 8'h40, 6, 0);
        addVec(0, 2, 8'h7F, 0, 8'h40, 6, 0);

        // Pointer wrap: ptr=0 puts bit 0 first, then bit 7
        addVec(1, 3, 8'h02, 1, 8'h02, 1, 0);
        addVec(0, 3, 8'h00, 1, 8'h00, 0, 0);
        addVec(0, 3, 8'h03, 1, 8'h01, 0, 0);
        addVec(0, 3, 8'h00, 1, 8'h00, 0, 0);
        addVec(0, 3, 8'h02, 1, 8'h02, 1, 0);
        addVec(0, 3, 8'h00, 1, 8'h00, 0, 0);
        addVec(0, 3, 8'h86, 1, 8'h80, 7, 0);

        // Hold limit: 16 cycles of grant, one timeout pulse, then the other requester
        addVec(1, 4, 8'h81, 1, 8'h80, 7, 0);
        for (int j = 0; j < 15; j++)
            addVec(0, 4, 8'h81, 1, 8'h80, 7, 0);
        addVec(0, 4, 8'h81, 1, 8'h00, 0, 1);
        addVec(0, 4, 8'h81, 1, 8'h01, 0, 0);
        addVec(0, 4, 8'h80, 1, 8'h00, 0, 0);
        addVec(0, 4, 8'h81, 1, 8'h80, 7, 0);

        // Owner releases on the very edge the limit is reached: no timeout
        addVec(1, 5, 8'h01, 1, 8'h01, 0, 0);
        for (int j = 0; j < 15; j++)
            addVec(0, 5, 8'h01, 1, 8'h01, 0, 0);
        addVec(0, 5, 8'h00, 1, 8'h00, 0, 0);
        addVec(0, 5, 8'h00, 1, 8'h00, 0, 0);
    endtask

    // Main sequence: reset check, vector table, then multi-cycle corner cases.
    initial begin
        int bad;
        rst_n  = 1'b0;
        req    = 8'd0;
        rr_en  = 1'b1;
        req2   = 8'd0;
        rr_en2 = 1'b1;

        doReset();
        checkOutput("reset", 0, 8'h00, 3'd0, 1'b0);
        applyStimulus(8'h00, 1'b1);
        checkOutput("idle_no_req", 0, 8'h00, 3'd0, 1'b0);

        buildTable();
        foreach (vecs[i]) begin
            if (vecs[i].do_rst)
                doReset();
            applyStimulus(vecs[i].req, vecs[i].rr_en);
            checkOutput(secName(vecs[i].sec), i, vecs[i].exp_gnt,
                        vecs[i].exp_id, vecs[i].exp_timeout);
        end

        // Asynchronous reset in the middle of a grant, with ptr moved off 7 first
        doReset();
        applyStimulus(8'h08, 1'b1);
        checkOutput("async_pre", 0, 8'h08, 3'd3, 1'b0);
        applyStimulus(8'h00, 1'b1);
        checkOutput("async_pre", 1, 8'h00, 3'd0, 1'b0);
        applyStimulus(8'hFF, 1'b1);
        checkOutput("async_pre", 2, 8'h04, 3'd2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_mid", 0, 8'h00, 3'd0, 1'b0);
        #1;
        rst_n = 1'b1;
        applyStimulus(8'hFF, 1'b1);
        checkOutput("async_post", 0, 8'h80, 3'd7, 1'b0);

        // No hold limit: a 300-cycle grant never times out and the counter saturates
        doReset();
        req2   = 8'h01;
        rr_en2 = 1'b1;
        bad    = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            if (gnt2 !== 8'h01 || gnt_id2 !== 3'd0 || gnt_valid2 !== 1'b1 || timeout2 !== 1'b0)
                bad++;
        end
        checkValue("nolimit_bad_cycles", bad, 0);
        checkValue("nolimit_hold_sat", int'(u_nolimit.hold_cnt_q), 255);
        req2 = 8'h00;
        @(posedge clk);
        #1;
        checkValue("nolimit_release_gnt", int'(gnt2), 0);
        checkValue("nolimit_release_timeout", int'(timeout2), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- 8-requester arbiter for one shared resource (bus port, memory port, CSR write path) in the NPC.
- Picks one requester using a rotating-priority encoder, or fixed priority with highest index winning.
- Holds the grant until the owner drops its request or a hold limit expires.
- Registered one-hot and binary grant outputs; sits between requesters and the shared resource's mux select.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one grant may stay high; 0 disables the limit.
- CNT_W, 8, width of the hold counter; MAX_HOLD must be at most 2^CNT_W - 1.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request vector; bit i is requester i and stays high while it wants or owns the resource.
- rr_en  input  1  1 = rotating priority; 0 = fixed priority (7 highest, 0 lowest).
- gnt  output  8  one-hot grant, registered; all zero when nothing is granted.
- gnt_id  output  3  binary index of the granted requester, registered; 0 when gnt_valid=0.
- gnt_valid  output  1  high when gnt is non-zero.
- timeout  output  1  one-cycle pulse, registered; high in the cycle after a grant is revoked by the MAX_HOLD limit.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - gnt=0, gnt_id=0, gnt_valid=0, timeout=0.
  - State=IDLE, ptr=7, hold_cnt=0.
- Priority search (combinational):
  - Search order is ptr, ptr-1, ..., 0, 7, ..., ptr+1, mod 8.
  - The first set bit of req in that order wins.
  - When rr_en=0, the search uses 7 regardless of ptr, which gives plain high-to-low priority.
- State IDLE:
  - If req != 0 at a rising edge: state=GRANT, gnt=onehot(winner), gnt_id=winner, gnt_valid=1, hold_cnt=1.
  - Grant latency is 1 cycle from req being sampled.
  - If req == 0: outputs stay zero.
- State GRANT (owner k = gnt_id):
  - Normal release: if req[k]=0 at an edge, then gnt/gnt_valid/gnt_id clear, state=IDLE, ptr=(k-1) mod 8, timeout=0.
  - Timeout release: else if MAX_HOLD != 0 and hold_cnt == MAX_HOLD at an edge, then grant clears, state=IDLE, ptr=(k-1) mod 8, timeout=1 for exactly one cycle.
  - Otherwise the grant holds and hold_cnt increments; it saturates at the all-ones value and never wraps.
- Grant rules:
  - Minimum one IDLE cycle between consecutive grants; gnt is low for at least 1 cycle at every handover.
  - Changes to other req bits during GRANT have no effect; there is no preemption.
- ptr update:
  - ptr updates on every release, including when rr_en=0.
  - Toggling rr_en mid-grant has no effect until the next arbitration.
- Timed-out requester:
  - It may keep req high and is re-arbitrated normally.
  - With rr_en=1 it has lowest priority for the next decision.
- Simultaneous events: if req[k] falls on the same edge where the hold limit is reached, treat it as a normal release with timeout=0.
- Wrap-around:
  - k=0 gives ptr=7.
  - With ptr=0, bit 0 has top priority, then bit 7.
- Reset mid-grant drops gnt immediately, without waiting for a clock edge.
- Invariants, checked by assertions:
  - gnt is zero or one-hot.
  - gnt_valid == |gnt.
  - gnt_id == encode(gnt).
  - timeout is never high while gnt_valid=1.

Test Plan:
- Reset, then req=8'b0010_0100, rr_en=1: after 1 edge gnt=8'b0010_0000, gnt_id=5. Drop req[5]: next cycle gnt=0. Following edge gnt=8'b0000_0100, gnt_id=2.
- Round-robin fairness, rr_en=1, req=8'hFF held, each owner drops for 1 cycle after 3 cycles: grant order 7,6,5,4,3,2,1,0,7. Owner 0 hands over to 7, covering the ptr wrap.
- Fixed priority, rr_en=0, req=8'hFF, each owner releases briefly: 7 wins every arbitration while req[7] is high. Clear req[7]: 6 wins.
- Timeout, MAX_HOLD=16, req=8'b1000_0001 held: gnt[7] high 16 cycles, then timeout=1 for one cycle with gnt=0. Next grant is gnt=8'b0000_0001.
- Release on the limit edge: req[k] falls on the edge where hold_cnt==MAX_HOLD -> timeout stays 0, normal release. With MAX_HOLD=0, a grant held 300 cycles never times out and hold_cnt saturates.
- Assert rst_n=0 asynchronously mid-grant: gnt/gnt_valid/gnt_id go to 0 before the next clk edge. After release, ptr=7 and req=8'hFF -> gnt_id=7.
